seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
Controller that runs bounded detection windows over a serial bit stream using an embedded dual-pattern Mealy detector (101 and 0110, overlapping).
- On start, it arms the detector and accepts bits under a valid/ready handshake.
- It counts each pattern separately and ends the window on match target, window expiry or abort.
- It reports status to the host/sequencer that owns the serial channel.

Parameters:
WIN_W, 8, width of window length (bits per window, 1..2^WIN_W-1)
CNT_W, 4, width of each per-pattern match counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
start  input  1  request new window; sampled only in IDLE
abort  input  1  terminate current window; sampled in ARM/RUN
win_len  input  WIN_W  number of bits in window, latched on start
match_target  input  CNT_W+1  total matches ending window early; 0 = disabled; latched on start
din_valid  input  1  serial bit valid
din  input  1  serial bit
din_ready  output  1  controller accepts bit (high only in RUN)
busy  output  1  high in ARM, RUN, DONE
hit  output  1  one-cycle pulse, registered, on any detection
cnt_101  output  CNT_W  101 detections in window, saturating
cnt_0110  output  CNT_W  0110 detections in window, saturating
status  output  2  00 none, 01 target reached, 10 window expired, 11 aborted
done  output  1  one-cycle pulse marking window end

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0, latched win_len/target and detector state cleared.
- Accept = din_valid & din_ready. The detector and bit counter advance only on accept; idle cycles in RUN do not alter detector state.
- FSM states IDLE, ARM, RUN, DONE.
- IDLE:
  - start=1, win_len!=0 -> latch win_len into bits_left and latch match_target; clear cnt_101, cnt_0110, status; go to ARM.
  - start=1, win_len==0 -> clear counters, status=10, go to DONE.
- ARM: exactly one cycle. Synchronously clears detector to reset state; din_ready=0. Goes to RUN; if abort=1, goes to DONE with status=11.
- RUN: din_ready=1. On each accepted bit:
  - bits_left decrements.
  - A detector output increments the matching counter (saturating at 2^CNT_W-1) and drives hit=1 in the next cycle.
  - 101 ends in 1 and 0110 ends in 0, so at most one detection per bit.
- RUN exit conditions, highest priority first:
  - abort=1 -> DONE, status=11; a bit accepted in the same cycle is still counted.
  - match_target!=0 and total matches including this bit (unsaturated, CNT_W+1 bits) >= target -> DONE, status=01.
  - Accepted bit makes bits_left 0 -> DONE, status=10; if the target is also met on the same bit, status=01.
- DONE: done=1, din_ready=0 for exactly one cycle, then IDLE.
- Counters and status hold their values until the next accepted start.
- Latency: last accepted bit at edge k gives counters, hit and state=DONE updated at edge k; done is high for cycle k..k+1.
- start outside IDLE is ignored. abort in IDLE/DONE is ignored.
- Detector: Mealy, overlapping matches, e.g. 01101 gives 0110 at bit 4 and 101 at bit 5.
- Reset asserted mid-window aborts without a done pulse; all outputs return to 0.

Decomposition:
- Package seq_detect_pkg:
  - FSM state encoding (IDLE, ARM, RUN, DONE).
  - Status constants (ST_NONE, ST_TARGET, ST_EXPIRED, ST_ABORT).
  - Detector state encoding.
- Sub-module dual_seq_core: clk, reset, en, clr, din; combinational outputs det_101 and det_0110.
  - Mealy FSM tracking the longest useful suffix of the two patterns.
  - Advances only when en=1; clr has priority over en.

Test Plan:
- Window 15, target 0, stream 0,1,1,0,1,1,0,0,1,0,1,0,1,1,0 streamed with din_valid continuous -> hit pulses after bits 4,5,7,11,13,15; final cnt_101=3, cnt_0110=3, status=10, done one cycle after bit 15.
- Same stream, target 4 -> 4th match on bit 11; cnt_101=2, cnt_0110=2, status=01, din_ready low from cycle after bit 11; bits 12-15 not accepted.
- Same stream with din_valid low for 3 cycles between bits 4 and 5 -> identical counts and hit order as scenario 1; stall does not break the 0110/101 overlap.
- win_len=0 with start -> ARM/RUN skipped, done on next cycle, status=10, counters 0; then abort in RUN after 5 bits of the stream -> status=11, cnt_101=1, cnt_0110=1.
- CNT_W=2 with window 40 of repeated 10 -> cnt_101 saturates at 3, status=10, no wrap.
- Reset pulled low mid-RUN, released, new start -> all outputs 0 during reset, no done pulse, detector history cleared (first 01 after restart plus 1 still needs the full 101).

Source files
------------

// File: rtl/seq_detect_pkg.sv
// ============================================================================
// Module   : seq_detect_pkg
// Purpose  : Shared encodings for the windowed dual-pattern sequence detector
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_detect_pkg;

  // Window controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } ctrl_state_t;

  // Window termination status reported to the host
  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_TARGET  = 2'b01;
  localparam logic [1:0] ST_EXPIRED = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  // Detector states: longest suffix of the accepted stream that is still a
  // prefix of either 101 or 0110 (D_E = nothing seen since clear)
  typedef enum logic [2:0] {
    D_E   = 3'd0,
    D_0   = 3'd1,
    D_1   = 3'd2,
    D_01  = 3'd3,
    D_10  = 3'd4,
    D_011 = 3'd5
  } det_state_t;

endpackage

`default_nettype wire

// File: rtl/dual_seq_core.sv
// ============================================================================
// Module   : dual_seq_core
// Purpose  : Overlapping Mealy detector for the patterns 101 and 0110
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dual_seq_core
  import seq_detect_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic det_101,
  output logic det_0110
);

  det_state_t state;
  det_state_t state_nxt;

  // Suffix register: clear wins over advance, and it only moves on en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= D_E;
    end else if (clr) begin
      state <= D_E;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  // Suffix transitions; detections are Mealy outputs valid only while en
  always_comb begin
    state_nxt = state;
    det_101   = 1'b0;
    det_0110  = 1'b0;
    case (state)
      D_E:   state_nxt = din ? D_1   : D_0;
      D_0:   state_nxt = din ? D_01  : D_0;
      D_1:   state_nxt = din ? D_1   : D_10;
      D_01:  state_nxt = din ? D_011 : D_10;
      D_10: begin
        // "101" seen; its tail "01" is the start of 0110
        if (din) begin
          state_nxt = D_01;
          det_101   = en;
        end else begin
          state_nxt = D_0;
        end
      end
      D_011: begin
        // "0110" seen; its tail "10" is the start of 101
        if (din) begin
          state_nxt = D_1;
        end else begin
          state_nxt = D_10;
          det_0110  = en;
        end
      end
      default: state_nxt = D_E;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
// ============================================================================
// Module   : seq_detect_ctrl
// Purpose  : Bounded detection-window controller around dual_seq_core
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int WIN_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W:0]   match_target,
  input  logic             din_valid,
  input  logic             din,
  output logic             din_ready,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] cnt_101,
  output logic [CNT_W-1:0] cnt_0110,
  output logic [1:0]       status,
  output logic             done
);

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic [1:0]       status_nxt;
  logic [WIN_W-1:0] bits_left;
  logic [CNT_W:0]   target;
  logic [CNT_W:0]   total;
  logic [CNT_W:0]   total_inc;
  logic             accept;
  logic             det_101;
  logic             det_0110;
  logic             det_any;
  logic             target_met;
  logic             last_bit;
  logic             load_win;
  logic             clear_cnt;

  assign din_ready = (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = din_valid & din_ready;
  assign det_any   = det_101 | det_0110;

  // Total is wider than either per-pattern counter so the target compare
  // still sees the real match count after a per-pattern counter saturates
  assign total_inc  = (det_any && (total != '1)) ? total + 1'b1 : total;
  assign target_met = (target != '0) && (total_inc >= target);
  assign last_bit   = (bits_left == WIN_W'(1));

  dual_seq_core u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (accept),
    .clr      (state == S_ARM),
    .din      (din),
    .det_101  (det_101),
    .det_0110 (det_0110)
  );

  // Controller state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, window-end status and datapath load/clear strobes
  always_comb begin
    state_nxt  = state;
    status_nxt = status;
    load_win   = 1'b0;
    clear_cnt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clear_cnt = 1'b1;
          if (win_len != '0) begin
            load_win   = 1'b1;
            status_nxt = ST_NONE;
            state_nxt  = S_ARM;
          end else begin
            status_nxt = ST_EXPIRED;
            state_nxt  = S_DONE;
          end
        end
      end
      S_ARM: begin
        if (abort) begin
          status_nxt = ST_ABORT;
          state_nxt  = S_DONE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          status_nxt = ST_ABORT;
          state_nxt  = S_DONE;
        end else if (accept && target_met) begin
          status_nxt = ST_TARGET;
          state_nxt  = S_DONE;
        end else if (accept && last_bit) begin
          status_nxt = ST_EXPIRED;
          state_nxt  = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Window datapath: bit budget, latched target, match counters, hit pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits_left <= '0;
      target    <= '0;
      total     <= '0;
      cnt_101   <= '0;
      cnt_0110  <= '0;
      status    <= ST_NONE;
      hit       <= 1'b0;
    end else begin
      status <= status_nxt;
      hit    <= accept & det_any;
      if (clear_cnt) begin
        cnt_101  <= '0;
        cnt_0110 <= '0;
        total    <= '0;
      end else if (accept) begin
        total <= total_inc;
        if (det_101 && (cnt_101 != '1)) begin
          cnt_101 <= cnt_101 + 1'b1;
        end
        if (det_0110 && (cnt_0110 != '1)) begin
          cnt_0110 <= cnt_0110 + 1'b1;
        end
      end
      if (load_win) begin
        bits_left <= win_len;
        target    <= match_target;
      end else if (accept) begin
        bits_left <= bits_left - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
// ============================================================================
// Module   : tb_seq_detect_ctrl
// Purpose  : Self-checking bench for seq_detect_ctrl (CNT_W=4 and CNT_W=2)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic [7:0] win_len = '0;
  logic [4:0] match_target = '0;

  logic       din_ready_a, busy_a, hit_a, done_a;
  logic [3:0] c101_a, c0110_a;
  logic [1:0] status_a;
  logic       din_ready_b, busy_b, hit_b, done_b;
  logic [1:0] c101_b, c0110_b;
  logic [1:0] status_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference results for the current window
  int         stream[$];
  int         exp_hit[256];
  int         exp_len;
  int         exp_n101;
  int         exp_n0110;
  logic [1:0] exp_status;

  seq_detect_ctrl #(.WIN_W(8), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .win_len(win_len), .match_target(match_target),
    .din_valid(din_valid), .din(din), .din_ready(din_ready_a),
    .busy(busy_a), .hit(hit_a), .cnt_101(c101_a), .cnt_0110(c0110_a),
    .status(status_a), .done(done_a)
  );

  seq_detect_ctrl #(.WIN_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .win_len(win_len), .match_target(match_target[2:0]),
    .din_valid(din_valid), .din(din), .din_ready(din_ready_b),
    .busy(busy_b), .hit(hit_b), .cnt_101(c101_b), .cnt_0110(c0110_b),
    .status(status_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Reference: pattern matching on the accepted-bit history of this window.
  // abort_at: -1 none, 0 abort during arming, k>0 abort together with bit k.
  task automatic model(input int win, input int tgt, input int abort_at);
    int h;
    int d101;
    int d0110;
    h = 0; exp_n101 = 0; exp_n0110 = 0; exp_len = 0; exp_status = 2'b00;
    if (abort_at == 0) begin
      exp_status = 2'b11;
      return;
    end
    for (int i = 0; i < win; i++) begin
      h = ((h << 1) | stream[i]) & 15;
      d101  = (i >= 2 && (h & 7) == 5) ? 1 : 0;
      d0110 = (i >= 3 && h == 6) ? 1 : 0;
      exp_hit[i] = d101 | d0110;
      exp_n101  += d101;
      exp_n0110 += d0110;
      exp_len = i + 1;
      if (abort_at == i + 1) begin exp_status = 2'b11; break; end
      if (tgt != 0 && exp_n101 + exp_n0110 >= tgt) begin exp_status = 2'b01; break; end
      if (i + 1 == win) begin exp_status = 2'b10; break; end
    end
  endtask

  // Full window: start, arm, stream with optional stalls/abort, done, idle
  task automatic run_window(input string name, input int win, input int tgt,
                            input int abort_at, input bit rnd_stall,
                            input int stall_at, input int stall_len);
    int acc, guard, stall_cnt, e;
    bit go;
    logic [3:0] e101a, e0110a;
    logic [1:0] e101b, e0110b;
    model(win, tgt, abort_at);
    e101a  = 4'((exp_n101  > 15) ? 15 : exp_n101);
    e0110a = 4'((exp_n0110 > 15) ? 15 : exp_n0110);
    e101b  = 2'((exp_n101  > 3) ? 3 : exp_n101);
    e0110b = 2'((exp_n0110 > 3) ? 3 : exp_n0110);
    @(negedge clk);
    start = 1'b1; win_len = 8'(win); match_target = 5'(tgt);
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy_a !== 1'b1 || din_ready_a !== 1'b0 || busy_b !== 1'b1 || din_ready_b !== 1'b0) begin
      n_fail++;
      $display("FAIL %s arm: busy=%b/%b ready=%b/%b expected busy=1 ready=0",
               name, busy_a, busy_b, din_ready_a, din_ready_b);
    end
    abort = (abort_at == 0);
    @(negedge clk);
    abort = 1'b0;
    acc = 0; guard = 0; stall_cnt = 0;
    while (acc < exp_len && guard < 2000) begin
      guard++;
      n_tests++;
      if (din_ready_a !== 1'b1 || din_ready_b !== 1'b1) begin
        n_fail++;
        $display("FAIL %s ready bit%0d: got %b/%b expected 1", name, acc + 1, din_ready_a, din_ready_b);
      end
      go = 1'b1;
      if (acc == stall_at && stall_cnt < stall_len) begin
        go = 1'b0;
        stall_cnt++;
      end else if (rnd_stall && $urandom_range(0, 3) == 0) begin
        go = 1'b0;
      end
      din_valid = go;
      din       = go ? stream[acc][0] : 1'($urandom_range(0, 1));
      abort     = go && (acc + 1 == abort_at);
      @(negedge clk);
      din_valid = 1'b0; abort = 1'b0;
      e = 0;
      if (go) begin
        e = exp_hit[acc];
        acc++;
      end
      n_tests++;
      if (hit_a !== 1'(e) || hit_b !== 1'(e)) begin
        n_fail++;
        $display("FAIL %s hit after bit%0d: got %b/%b expected %0d", name, acc, hit_a, hit_b, e);
      end
    end
    if (guard >= 2000) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: accepted %0d of %0d bits", name, acc, exp_len);
    end
    n_tests++;
    if ({done_a, din_ready_a, busy_a, status_a, c101_a, c0110_a} !==
        {1'b1, 1'b0, 1'b1, exp_status, e101a, e0110a}) begin
      n_fail++;
      $display("FAIL %s end A: done=%b rdy=%b busy=%b st=%b c101=%0d c0110=%0d expected done=1 rdy=0 busy=1 st=%b c101=%0d c0110=%0d",
               name, done_a, din_ready_a, busy_a, status_a, c101_a, c0110_a, exp_status, e101a, e0110a);
    end
    n_tests++;
    if ({done_b, din_ready_b, busy_b, status_b, c101_b, c0110_b} !==
        {1'b1, 1'b0, 1'b1, exp_status, e101b, e0110b}) begin
      n_fail++;
      $display("FAIL %s end B: done=%b rdy=%b busy=%b st=%b c101=%0d c0110=%0d expected done=1 rdy=0 busy=1 st=%b c101=%0d c0110=%0d",
               name, done_b, din_ready_b, busy_b, status_b, c101_b, c0110_b, exp_status, e101b, e0110b);
    end
    @(negedge clk);
    n_tests++;
    if ({done_a, busy_a, hit_a, status_a, c101_a, c0110_a} !== {3'b000, exp_status, e101a, e0110a} ||
        {done_b, busy_b, hit_b, status_b, c101_b, c0110_b} !== {3'b000, exp_status, e101b, e0110b}) begin
      n_fail++;
      $display("FAIL %s idle hold: done=%b/%b busy=%b/%b st=%b/%b c101=%0d/%0d expected done=0 busy=0 st=%b c101=%0d/%0d",
               name, done_a, done_b, busy_a, busy_b, status_a, status_b, c101_a, c101_b, exp_status, e101a, e101b);
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({din_ready_a, busy_a, hit_a, c101_a, c0110_a, status_a, done_a} !== '0 ||
        {din_ready_b, busy_b, hit_b, c101_b, c0110_b, status_b, done_b} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: busy=%b/%b st=%b/%b done=%b/%b expected all zero",
               busy_a, busy_b, status_a, status_b, done_a, done_b);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_scenario();
    stream = '{0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 1, 0};
  endtask

  task automatic test_window_expiry();
    load_scenario();
    run_window("expiry", 15, 0, -1, 1'b0, -1, 0);
  endtask

  task automatic test_target();
    load_scenario();
    run_window("target", 15, 4, -1, 1'b0, -1, 0);
  endtask

  task automatic test_stall();
    load_scenario();
    run_window("stall", 15, 0, -1, 1'b0, 4, 3);
  endtask

  task automatic test_zero_window();
    @(negedge clk);
    start = 1'b1; win_len = 8'd0; match_target = 5'd0;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({done_a, busy_a, din_ready_a, status_a, c101_a, c0110_a} !== {3'b110, 2'b10, 8'd0} ||
        {done_b, busy_b, din_ready_b, status_b, c101_b, c0110_b} !== {3'b110, 2'b10, 4'd0}) begin
      n_fail++;
      $display("FAIL zero window: done=%b/%b st=%b/%b c101=%0d/%0d expected done=1 st=10 counts 0",
               done_a, done_b, status_a, status_b, c101_a, c101_b);
    end
    @(negedge clk);
    n_tests++;
    if ({done_a, busy_a, done_b, busy_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL zero window idle: done=%b/%b busy=%b/%b expected 0", done_a, done_b, busy_a, busy_b);
    end
  endtask

  task automatic test_abort();
    load_scenario();
    run_window("abort run", 15, 0, 5, 1'b0, -1, 0);
    run_window("abort arm", 15, 0, 0, 1'b0, -1, 0);
  endtask

  task automatic test_saturation();
    stream = {};
    for (int i = 0; i < 40; i++) stream.push_back((i % 2 == 0) ? 1 : 0);
    run_window("saturate", 40, 0, -1, 1'b0, -1, 0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1; win_len = 8'd20; match_target = 5'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    din_valid = 1'b1; din = 1'b1;
    @(negedge clk);
    din = 1'b0;
    @(negedge clk);
    din_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if ({din_ready_a, busy_a, hit_a, c101_a, c0110_a, status_a, done_a} !== '0 ||
          {din_ready_b, busy_b, hit_b, c101_b, c0110_b, status_b, done_b} !== '0) begin
        n_fail++;
        $display("FAIL mid-run reset cycle%0d: busy=%b/%b done=%b/%b expected all zero",
                 i, busy_a, busy_b, done_a, done_b);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    stream = '{1, 0, 1, 1};
    run_window("after reset", 4, 0, -1, 1'b0, -1, 0);
  endtask

  task automatic test_random();
    int win, tgt, ab;
    for (int w = 0; w < 8; w++) begin
      win = int'($urandom_range(1, 30));
      tgt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, win)) : -1;
      stream = {};
      for (int i = 0; i < win; i++) stream.push_back(int'($urandom_range(0, 1)));
      run_window("random", win, tgt, ab, 1'b1, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_window_expiry();
    test_target();
    test_stall();
    test_zero_window();
    test_abort();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
